// File: rtl/cache_arbiter_if.sv
// cache_arbiter_if: miss-path bus shared by the I-cache, the D-cache and the
// single L2/memory port. The slave modport is the arbiter's view. The master
// modport is the view of the caches and memory around it.
interface cache_arbiter_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int LINE_WIDTH = 128
);
   logic                  i_read;
   logic [ADDR_WIDTH-1:0] i_address;
   logic [LINE_WIDTH-1:0] i_rdata;
   logic                  i_resp;

   logic                  d_read;
   logic                  d_write;
   logic [ADDR_WIDTH-1:0] d_address;
   logic [LINE_WIDTH-1:0] d_wdata;
   logic [LINE_WIDTH-1:0] d_rdata;
   logic                  d_resp;

   logic                  l2_read;
   logic                  l2_write;
   logic [ADDR_WIDTH-1:0] l2_address;
   logic [LINE_WIDTH-1:0] l2_wdata;
   logic [LINE_WIDTH-1:0] l2_rdata;
   logic                  l2_resp;

   modport slave (
      input  i_read, i_address, d_read, d_write, d_address, d_wdata,
             l2_rdata, l2_resp,
      output i_rdata, i_resp, d_rdata, d_resp,
             l2_read, l2_write, l2_address, l2_wdata
   );

   modport master (
      output i_read, i_address, d_read, d_write, d_address, d_wdata,
             l2_rdata, l2_resp,
      input  i_rdata, i_resp, d_rdata, d_resp,
             l2_read, l2_write, l2_address, l2_wdata
   );
endinterface

// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one L2/memory port between the I-cache and D-cache
// miss paths. Only one line fill or writeback is outstanding at a time, and each
// completion is routed back to the cache that owns it.
// Optional feature macro: CACHE_ARB_ROUND_ROBIN_EN. When it is defined, the
// arbiter alternates grants when both sides request. When it is undefined, the
// arbiter uses fixed D-over-I priority.
module cache_arbiter #(
   parameter int ADDR_WIDTH = 16,
   parameter int LINE_WIDTH = 128
) (
   input  logic              clk,
   input  logic              rst_n,
   cache_arbiter_if.slave    bus,
   output logic              arb_busy
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2
   } state_t;

   state_t                state_q;
   logic                  l2Read_q;
   logic                  l2Write_q;
   logic                  arbBusy_q;
   logic [ADDR_WIDTH-1:0] l2Address_q;
   logic [LINE_WIDTH-1:0] l2Wdata_q;
   logic [LINE_WIDTH-1:0] iRdata_q;
   logic [LINE_WIDTH-1:0] dRdata_q;

   logic                  dReq;
   logic                  iReq;
   logic                  grantD_d;
   logic                  grantI_d;
   logic                  iDone;
   logic                  dDone;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
   // 1 means D was granted last, 0 means I was granted last
   logic                  lastOwner_q;

   // Grant decision: on a tie, grant the side that was not served last
   always_comb begin
      dReq     = bus.d_read | bus.d_write;
      iReq     = bus.i_read;
      grantD_d = dReq & (~iReq | ~lastOwner_q);
      grantI_d = iReq & ~grantD_d;
   end

   // Track which side received the most recent grant
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lastOwner_q <= 1'b0;
      end else if (state_q == IDLE) begin
         if (grantD_d) begin
            lastOwner_q <= 1'b1;
         end else if (grantI_d) begin
            lastOwner_q <= 1'b0;
         end
      end
   end
`else
   // Grant decision: the D-cache always wins, and I waits for a D-free IDLE cycle
   always_comb begin
      dReq     = bus.d_read | bus.d_write;
      iReq     = bus.i_read;
      grantD_d = dReq;
      grantI_d = iReq & ~dReq;
   end
`endif

   // Completion is only recognised while a transfer is in flight
   always_comb begin
      iDone = (state_q == SERVE_I) && bus.l2_resp;
      dDone = (state_q == SERVE_D) && bus.l2_resp;
   end

   // Serving FSM: latch the owner's command at grant, hold it until l2_resp, then pass through one IDLE bubble
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         l2Read_q    <= 1'b0;
         l2Write_q   <= 1'b0;
         arbBusy_q   <= 1'b0;
         l2Address_q <= '0;
         l2Wdata_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (grantD_d) begin
                  state_q     <= SERVE_D;
                  l2Read_q    <= ~bus.d_write;
                  l2Write_q   <= bus.d_write;
                  l2Address_q <= bus.d_address;
                  l2Wdata_q   <= bus.d_wdata;
                  arbBusy_q   <= 1'b1;
               end else if (grantI_d) begin
                  state_q     <= SERVE_I;
                  l2Read_q    <= 1'b1;
                  l2Write_q   <= 1'b0;
                  l2Address_q <= bus.i_address;
                  l2Wdata_q   <= '0;
                  arbBusy_q   <= 1'b1;
               end
            end
            SERVE_I, SERVE_D: begin
               if (bus.l2_resp) begin
                  state_q   <= IDLE;
                  l2Read_q  <= 1'b0;
                  l2Write_q <= 1'b0;
                  arbBusy_q <= 1'b0;
               end
            end
            default: begin
               state_q   <= IDLE;
               l2Read_q  <= 1'b0;
               l2Write_q <= 1'b0;
               arbBusy_q <= 1'b0;
            end
         endcase
      end
   end

   // Remember each side's last fill data so the non-owner's rdata holds steady
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         iRdata_q <= '0;
         dRdata_q <= '0;
      end else begin
         if (iDone) begin
            iRdata_q <= bus.l2_rdata;
         end
         if (dDone) begin
            dRdata_q <= bus.l2_rdata;
         end
      end
   end

   assign bus.l2_read    = l2Read_q;
   assign bus.l2_write   = l2Write_q;
   assign bus.l2_address = l2Address_q;
   assign bus.l2_wdata   = l2Wdata_q;
   assign bus.i_resp     = iDone;
   assign bus.d_resp     = dDone;
   assign bus.i_rdata    = iDone ? bus.l2_rdata : iRdata_q;
   assign bus.d_rdata    = dDone ? bus.l2_rdata : dRdata_q;
   assign arb_busy       = arbBusy_q;

`ifndef SYNTHESIS
   // A D-side read and write raised together during service is a protocol error; it is served as a write
   dualRequestCheck: assert property (
      @(posedge clk) disable iff (!rst_n)
      (state_q == SERVE_D) |-> !(bus.d_read && bus.d_write)
   );
`endif

endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: directed bench for cache_arbiter. A scoreboard queue holds
// the L2 commands expected from each request. A small memory responder pops them
// and checks the command, the response routing and the rdata holding.
// The CACHE_ARB_ROUND_ROBIN_EN macro selects the expected grant order.
module tb_cache_arbiter;

   typedef struct {
      logic         isD;
      logic         isWrite;
      logic [15:0]  addr;
      logic [127:0] wdata;
   } txn_t;

   logic clk;
   logic rst_n;
   logic arb_busy;

   txn_t         sbQ[$];
   int           testsRun;
   int           testsFailed;
   int           gap;
   logic         lastOwnerModel;
   logic         scramble;
   logic         dFirst;
   logic [127:0] lastIRdata;
   logic [127:0] lastDRdata;

   cache_arbiter_if #(.ADDR_WIDTH(16), .LINE_WIDTH(128)) bus ();

   cache_arbiter #(.ADDR_WIDTH(16), .LINE_WIDTH(128)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .arb_busy (arb_busy)
   );

   // Free-running 10-time-unit clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case the run ever wedges
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: run did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         testsFailed++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic iRead, input logic [15:0] iAddr,
                                input logic dRead, input logic dWrite,
                                input logic [15:0] dAddr, input logic [127:0] dWdata);
      @(negedge clk);
      bus.i_read    = iRead;
      bus.i_address = iAddr;
      bus.d_read    = dRead;
      bus.d_write   = dWrite;
      bus.d_address = dAddr;
      bus.d_wdata   = dWdata;
      #1;
   endtask

   // Memory responder: wait for a command, match it with the scoreboard, respond after 'latency' command cycles
   // dropMode: 0 drops the owner's request after resp, 1 keeps all requests, 2 drops all requests
   task automatic memServe(input int latency, input logic [127:0] rdataIn,
                           input int dropMode, output int waited);
      txn_t exp;
      logic respNow;
      waited = 0;
      while (!(bus.l2_read || bus.l2_write) && waited < 20) begin
         @(negedge clk);
         #1;
         waited++;
      end
      checkOutput("cmdSeen", 128'(bus.l2_read | bus.l2_write), 128'd1);
      checkOutput("sbDepth", 128'(sbQ.size() > 0), 128'd1);
      if (sbQ.size() == 0) return;
      exp = sbQ.pop_front();
      for (int c = 1; c <= latency; c++) begin
         checkOutput("l2Read", 128'(bus.l2_read), 128'(!exp.isWrite));
         checkOutput("l2Write", 128'(bus.l2_write), 128'(exp.isWrite));
         checkOutput("l2Address", 128'(bus.l2_address), 128'(exp.addr));
         if (exp.isWrite) checkOutput("l2Wdata", bus.l2_wdata, exp.wdata);
         checkOutput("busyServe", 128'(arb_busy), 128'd1);
         respNow = (c == latency);
         if (respNow) begin
            bus.l2_rdata = rdataIn;
            bus.l2_resp  = 1'b1;
            #1;
         end
         checkOutput("iResp", 128'(bus.i_resp), 128'(respNow && !exp.isD));
         checkOutput("dResp", 128'(bus.d_resp), 128'(respNow && exp.isD));
         if (respNow) begin
            if (exp.isD) begin
               checkOutput("dRdata", bus.d_rdata, rdataIn);
               checkOutput("iRdataHold", bus.i_rdata, lastIRdata);
               lastDRdata = rdataIn;
            end else begin
               checkOutput("iRdata", bus.i_rdata, rdataIn);
               checkOutput("dRdataHold", bus.d_rdata, lastDRdata);
               lastIRdata = rdataIn;
            end
         end
         if (c == 1 && scramble) begin
            bus.d_address = ~bus.d_address;
            bus.d_wdata   = ~bus.d_wdata;
            bus.i_address = ~bus.i_address;
         end
         @(negedge clk);
         bus.l2_resp = 1'b0;
         if (respNow) begin
            if (dropMode == 2 || (dropMode == 0 && !exp.isD)) bus.i_read = 1'b0;
            if (dropMode == 2 || (dropMode == 0 && exp.isD)) begin
               bus.d_read  = 1'b0;
               bus.d_write = 1'b0;
            end
         end
         #1;
      end
      lastOwnerModel = exp.isD;
      checkOutput("bubbleBusy", 128'(arb_busy), 128'd0);
      checkOutput("bubbleCmd", 128'(bus.l2_read | bus.l2_write), 128'd0);
   endtask

   // Directed sequence
   initial begin
      testsRun       = 0;
      testsFailed    = 0;
      lastOwnerModel = 1'b0;
      scramble       = 1'b0;
      lastIRdata     = '0;
      lastDRdata     = '0;
      rst_n          = 1'b0;
      bus.i_read     = 1'b0;
      bus.i_address  = '0;
      bus.d_read     = 1'b0;
      bus.d_write    = 1'b0;
      bus.d_address  = '0;
      bus.d_wdata    = '0;
      bus.l2_rdata   = '0;
      bus.l2_resp    = 1'b0;

      // Reset values
      repeat (2) @(negedge clk);
      #1;
      checkOutput("rstL2Read", 128'(bus.l2_read), 128'd0);
      checkOutput("rstL2Write", 128'(bus.l2_write), 128'd0);
      checkOutput("rstL2Address", 128'(bus.l2_address), 128'd0);
      checkOutput("rstL2Wdata", bus.l2_wdata, 128'd0);
      checkOutput("rstResps", 128'({bus.i_resp, bus.d_resp}), 128'd0);
      checkOutput("rstIRdata", bus.i_rdata, 128'd0);
      checkOutput("rstDRdata", bus.d_rdata, 128'd0);
      checkOutput("rstBusy", 128'(arb_busy), 128'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Async reset in the middle of a D-side fill
      applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 16'h5000, 128'd0);
      @(negedge clk);
      #1;
      checkOutput("t1CmdUp", 128'(bus.l2_read), 128'd1);
      #2;
      rst_n        = 1'b0;
      bus.l2_resp  = 1'b1;
      bus.l2_rdata = 128'hFACE;
      #1;
      checkOutput("t1RstRead", 128'(bus.l2_read), 128'd0);
      checkOutput("t1RstWrite", 128'(bus.l2_write), 128'd0);
      checkOutput("t1RstDResp", 128'(bus.d_resp), 128'd0);
      checkOutput("t1RstBusy", 128'(arb_busy), 128'd0);
      checkOutput("t1RstDRdata", bus.d_rdata, 128'd0);
      bus.l2_resp = 1'b0;
      bus.d_read  = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      lastOwnerModel = 1'b0;
      @(negedge clk);
      #1;
      checkOutput("t1IdleBusy", 128'(arb_busy), 128'd0);
      checkOutput("t1IdleCmd", 128'(bus.l2_read | bus.l2_write), 128'd0);

      // I-side fill answered on the 3rd command cycle
      sbQ.push_back('{isD: 1'b0, isWrite: 1'b0, addr: 16'h3000, wdata: 128'd0});
      applyStimulus(1'b1, 16'h3000, 1'b0, 1'b0, 16'h0000, 128'd0);
      memServe(3, {16{8'hA5}}, 0, gap);
      checkOutput("t2GrantLatency", 128'(gap), 128'd1);

      // D-side writeback; the requester's inputs change after grant
      scramble = 1'b1;
      sbQ.push_back('{isD: 1'b1, isWrite: 1'b1, addr: 16'h4410, wdata: 128'h1234});
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 16'h4410, 128'h1234);
      memServe(3, 128'h0000_DEAD_0000_BEEF, 0, gap);
      checkOutput("t3GrantLatency", 128'(gap), 128'd1);
      scramble = 1'b0;

      // Spurious l2_resp while idle
      @(negedge clk);
      bus.l2_rdata = 128'h5555_0000_AAAA;
      bus.l2_resp  = 1'b1;
      #1;
      checkOutput("t6IResp", 128'(bus.i_resp), 128'd0);
      checkOutput("t6DResp", 128'(bus.d_resp), 128'd0);
      checkOutput("t6IRdata", bus.i_rdata, lastIRdata);
      checkOutput("t6DRdata", bus.d_rdata, lastDRdata);
      @(negedge clk);
      bus.l2_resp = 1'b0;
      #1;
      checkOutput("t6Busy", 128'(arb_busy), 128'd0);
      checkOutput("t6Cmd", 128'(bus.l2_read | bus.l2_write), 128'd0);

      // I and D requests rise together
`ifdef CACHE_ARB_ROUND_ROBIN_EN
      dFirst = (lastOwnerModel == 1'b0);
`else
      dFirst = 1'b1;
`endif
      if (dFirst) begin
         sbQ.push_back('{isD: 1'b1, isWrite: 1'b0, addr: 16'h2200, wdata: 128'd0});
         sbQ.push_back('{isD: 1'b0, isWrite: 1'b0, addr: 16'h1100, wdata: 128'd0});
      end else begin
         sbQ.push_back('{isD: 1'b0, isWrite: 1'b0, addr: 16'h1100, wdata: 128'd0});
         sbQ.push_back('{isD: 1'b1, isWrite: 1'b0, addr: 16'h2200, wdata: 128'd0});
      end
      applyStimulus(1'b1, 16'h1100, 1'b1, 1'b0, 16'h2200, 128'd0);
      memServe(2, 128'h1111_2222_3333_4444, 0, gap);
      memServe(1, 128'h9999_8888_7777_6666, 0, gap);
      checkOutput("t4SecondGrantGap", 128'(gap), 128'd1);

`ifdef CACHE_ARB_ROUND_ROBIN_EN
      // Both sides request continuously after a reset, so grants alternate D,I,D,I
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      @(negedge clk);
      rst_n          = 1'b1;
      lastOwnerModel = 1'b0;
      lastIRdata     = '0;
      lastDRdata     = '0;
      for (int k = 0; k < 2; k++) begin
         sbQ.push_back('{isD: 1'b1, isWrite: 1'b0, addr: 16'h2A00, wdata: 128'd0});
         sbQ.push_back('{isD: 1'b0, isWrite: 1'b0, addr: 16'h1A00, wdata: 128'd0});
      end
      applyStimulus(1'b1, 16'h1A00, 1'b1, 1'b0, 16'h2A00, 128'd0);
      for (int k = 0; k < 4; k++) begin
         memServe(2, 128'(k + 32'hC0DE_0000), (k == 3) ? 2 : 1, gap);
         checkOutput("t5GrantGap", 128'(gap), 128'd1);
      end
`endif

      checkOutput("sbDrained", 128'(sbQ.size()), 128'd0);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
